// File: rtl/vga_pkg.sv
// Shared VGA timing package: default 640x480@60 timing and helpers
// used by the timing generator, colour and decider stages.
package vga_pkg;

  localparam int CNT_W        = 10;
  localparam int DIV_DEF      = 4;
  localparam int SYNC_DLY_DEF = 1;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  function automatic int total(
    input int act, input int fp,
    input int sw,  input int bp
  );
    return act + fp + sw + bp;
  endfunction

  function automatic int sync_lo(input int act, input int fp);
    return act + fp;
  endfunction

  function automatic int sync_hi(
    input int act, input int fp, input int sw
  );
    return act + fp + sw - 1;
  endfunction

  localparam int H_TOTAL_DEF =
    total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF =
    total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  typedef struct packed {
    logic             video_on;
    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;
    logic             frame_start;
  } vga_pix_t;

endpackage

// File: rtl/vga_timing_gen_pix_tick_gen.sv
// Pixel-rate tick divider: one-clk tick every DIV clocks.
module pix_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam logic [3:0] LAST = 4'(DIV - 1);

  logic [3:0] div_q, div_d;

  assign tick = (div_q == LAST);

  always_comb begin
    div_d = div_q + 4'd1;
    if (tick) div_d = 4'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) div_q <= 4'd0;
    else       div_q <= div_d;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters with registered pixel outputs and
// delayed active-low syncs aligned to the colour pipeline.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int DIV      = DIV_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int SYNC_DLY = SYNC_DLY_DEF
) (
  input  logic       clk,
  input  logic       reset,
  output logic       video_on,
  output logic [9:0] pixel_column,
  output logic [9:0] pixel_row,
  output logic       horiz_sync,
  output logic       vert_sync,
  output logic       frame_start
);

  localparam int HT = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VT = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [9:0] H_LAST = 10'(HT - 1);
  localparam logic [9:0] V_LAST = 10'(VT - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_LO  = 10'(sync_lo(H_ACTIVE, H_FP));
  localparam logic [9:0] HS_HI  = 10'(sync_hi(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [9:0] VS_LO  = 10'(sync_lo(V_ACTIVE, V_FP));
  localparam logic [9:0] VS_HI  = 10'(sync_hi(V_ACTIVE, V_FP, V_SYNC));

  if (HT > 1024 || VT > 1024 || DIV < 1 || DIV > 16 || SYNC_DLY < 0)
  begin : g_bad_params
    $error("vga_timing_gen: illegal timing parameters");
  end

  logic       tick;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       wrap_q, wrap_d;
  vga_pix_t   pix_q, pix_d;
  logic       hs_raw, vs_raw;

  logic [SYNC_DLY:0] hs_pipe_q, hs_pipe_d;
  logic [SYNC_DLY:0] vs_pipe_q, vs_pipe_d;

  pix_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    wrap_d  = 1'b0;
    if (tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = 10'd0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d = 10'd0;
          wrap_d  = 1'b1;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  // wrap_q marks the clk right after the (0,0) wrap edge
  always_comb begin
    pix_d.video_on    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    pix_d.col         = h_cnt_q;
    pix_d.row         = v_cnt_q;
    pix_d.frame_start = wrap_q;
    hs_raw = !((h_cnt_q >= HS_LO) && (h_cnt_q <= HS_HI));
    vs_raw = !((v_cnt_q >= VS_LO) && (v_cnt_q <= VS_HI));
  end

  always_comb begin
    hs_pipe_d    = hs_pipe_q;
    vs_pipe_d    = vs_pipe_q;
    hs_pipe_d[0] = hs_raw;
    vs_pipe_d[0] = vs_raw;
    for (int i = 1; i <= SYNC_DLY; i++) begin
      hs_pipe_d[i] = hs_pipe_q[i-1];
      vs_pipe_d[i] = vs_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      wrap_q    <= 1'b0;
      pix_q     <= '0;
      hs_pipe_q <= '1;
      vs_pipe_q <= '1;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      wrap_q    <= wrap_d;
      pix_q     <= pix_d;
      hs_pipe_q <= hs_pipe_d;
      vs_pipe_q <= vs_pipe_d;
    end
  end

  assign video_on     = pix_q.video_on;
  assign pixel_column = pix_q.col;
  assign pixel_row    = pix_q.row;
  assign frame_start  = pix_q.frame_start;
  assign horiz_sync   = hs_pipe_q[SYNC_DLY];
  assign vert_sync    = vs_pipe_q[SYNC_DLY];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken raster:
// DIV=2, H 8/2/3/3 (16), V 6/1/2/2 (11), SYNC_DLY=2, frame 352 clk.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       video_on;
  logic [9:0] pixel_column;
  logic [9:0] pixel_row;
  logic       horiz_sync;
  logic       vert_sync;
  logic       frame_start;

  int n_chk = 0;
  int n_fail = 0;
  int k = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_DLY(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .video_on     (video_on),
    .pixel_column (pixel_column),
    .pixel_row    (pixel_row),
    .horiz_sync   (horiz_sync),
    .vert_sync    (vert_sync),
    .frame_start  (frame_start)
  );

  typedef struct {
    int         k;
    logic       vo;
    logic [9:0] col;
    logic [9:0] row;
    logic       hs;
    logic       vs;
    logic       fs;
  } vec_t;

  vec_t tbl [17];

  function automatic logic [23:0] pack_out();
    return {video_on, pixel_column, pixel_row,
            horiz_sync, vert_sync, frame_start};
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // advance to k edges after reset release, sampling 1 time unit later
  task automatic adv(input int target);
    while (k < target) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  function automatic vec_t mk(int kk, logic vo, int col, int row,
                              logic hs, logic vs, logic fs);
    vec_t v;
    v.k = kk; v.vo = vo; v.col = 10'(col); v.row = 10'(row);
    v.hs = hs; v.vs = vs; v.fs = fs;
    return v;
  endfunction

  int hs_lo, vs_lo, vo_hi, fs_n, run, hs_run_max, vs_run, vs_run_max;
  int fs_k;

  initial begin
    tbl[0]  = mk(1,   1, 0,  0,  1, 1, 0);
    tbl[1]  = mk(3,   1, 1,  0,  1, 1, 0);
    tbl[2]  = mk(17,  0, 8,  0,  1, 1, 0);
    tbl[3]  = mk(22,  0, 10, 0,  1, 1, 0);
    tbl[4]  = mk(23,  0, 11, 0,  0, 1, 0);
    tbl[5]  = mk(28,  0, 13, 0,  0, 1, 0);
    tbl[6]  = mk(29,  0, 14, 0,  1, 1, 0);
    tbl[7]  = mk(33,  1, 0,  1,  1, 1, 0);
    tbl[8]  = mk(175, 1, 7,  5,  1, 1, 0);
    tbl[9]  = mk(177, 0, 8,  5,  1, 1, 0);
    tbl[10] = mk(226, 0, 0,  7,  1, 1, 0);
    tbl[11] = mk(227, 0, 1,  7,  1, 0, 0);
    tbl[12] = mk(290, 0, 0,  9,  1, 0, 0);
    tbl[13] = mk(291, 0, 1,  9,  1, 1, 0);
    tbl[14] = mk(351, 0, 15, 10, 1, 1, 0);
    tbl[15] = mk(353, 1, 0,  0,  1, 1, 1);
    tbl[16] = mk(354, 1, 0,  0,  1, 1, 0);

    #1 reset = 1'b1;
    #2;
    chk("reset_state", 32'(pack_out()),
        32'({1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0}));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    k = 0;

    foreach (tbl[i]) begin
      adv(tbl[i].k);
      chk($sformatf("vec_k%0d", tbl[i].k), 32'(pack_out()),
          32'({tbl[i].vo, tbl[i].col, tbl[i].row,
               tbl[i].hs, tbl[i].vs, tbl[i].fs}));
    end

    // one full frame period of statistics, k = 355..706
    hs_lo = 0; vs_lo = 0; vo_hi = 0; fs_n = 0; fs_k = -1;
    run = 0; hs_run_max = 0; vs_run = 0; vs_run_max = 0;
    for (int t = 355; t <= 706; t++) begin
      adv(t);
      if (!horiz_sync) begin hs_lo++; run++; end
      else run = 0;
      if (run > hs_run_max) hs_run_max = run;
      if (!vert_sync) begin vs_lo++; vs_run++; end
      else vs_run = 0;
      if (vs_run > vs_run_max) vs_run_max = vs_run;
      if (video_on) vo_hi++;
      if (frame_start) begin
        fs_n++;
        fs_k = k;
        chk("fs_pos", 32'({pixel_column, pixel_row}), 32'(0));
      end
    end
    chk("hs_low_clk", 32'(hs_lo), 32'(66));
    chk("hs_run", 32'(hs_run_max), 32'(6));
    chk("vs_low_clk", 32'(vs_lo), 32'(64));
    chk("vs_run", 32'(vs_run_max), 32'(64));
    chk("active_ticks", 32'(vo_hi / 2), 32'(48));
    chk("fs_count", 32'(fs_n), 32'(1));
    chk("fs_period", 32'(fs_k), 32'(705));

    // asynchronous mid-frame reset
    adv(800);
    #1 reset = 1'b1;
    #1;
    chk("midreset_state", 32'(pack_out()),
        32'({1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0}));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    k = 0;
    adv(1);
    chk("rel_k1", 32'(pack_out()),
        32'({1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0}));
    adv(2);
    chk("rel_k2_col", 32'(pixel_column), 32'(0));
    adv(3);
    chk("rel_k3_col", 32'(pixel_column), 32'(1));
    adv(22);
    chk("rel_hs_k22", 32'(horiz_sync), 32'(1));
    adv(23);
    chk("rel_hs_k23", 32'(horiz_sync), 32'(0));
    fs_n = 0;
    for (int t = 24; t <= 352; t++) begin
      adv(t);
      if (frame_start) fs_n++;
    end
    chk("rel_no_fs", 32'(fs_n), 32'(0));
    adv(353);
    chk("rel_fs_k353", 32'(frame_start), 32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter DIV, default 4: clk cycles per pixel tick (100 MHz clk to 25 MHz pixel rate); legal values 1..16.
REQ-002 Parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48: horizontal timing in pixel ticks.
REQ-003 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical timing in lines.
REQ-004 Parameter SYNC_DLY, default 1: extra clk delay on sync outputs, matching the registered colour stage downstream.
REQ-005 clk  input  1  system clock; all state on rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 video_on  output  1  high while the current pixel is inside the active area; consumed by the colour stage.
REQ-008 pixel_column  output  10  horizontal pixel index, 0..H_total-1.
REQ-009 pixel_row  output  10  vertical line index, 0..V_total-1.
REQ-010 horiz_sync  output  1  horizontal sync, active-low.
REQ-011 vert_sync  output  1  vertical sync, active-low.
REQ-012 frame_start  output  1  one-clk pulse at the start of each new frame.

Function
REQ-013 Tick divider counts 0..DIV-1 and wraps; tick asserts for exactly one clk when divider equals DIV-1; with DIV=1, tick is asserted every clk.
REQ-014 h_cnt advances by 1 on each tick; H_total = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); h_cnt wraps from H_total-1 to 0.
REQ-015 v_cnt advances by 1 only on a tick where h_cnt wraps; V_total default 525; v_cnt wraps from V_total-1 to 0.
REQ-016 On a tick with h_cnt=H_total-1 and v_cnt=V_total-1, both counters return to 0 on the same edge.
REQ-017 The module registers video_on = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE); latency is 1 clk after a counter change.
REQ-018 The module registers pixel_column/pixel_row from h_cnt/v_cnt with the same 1-clk latency as video_on; outside the active area they show the raw counts.
REQ-019 Raw hsync is low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (default 656..751), otherwise high.
REQ-020 Raw vsync is low for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (default 490..491), otherwise high.
REQ-021 horiz_sync/vert_sync are raw syncs registered (1 clk) and then passed through a SYNC_DLY-stage shift register; total latency is 1+SYNC_DLY clk.
REQ-022 frame_start asserts for one clk, aligned with video_on, when counters transition to (0,0) by wrap; it is not asserted on reset exit.
REQ-023 Widths: counters are 10 bits; parameter sums are computed in 32-bit and must fit in 10 bits (checked at elaboration).

Reset
REQ-024 Asynchronous reset clears divider, h_cnt and v_cnt to 0; video_on=0; pixel_row and pixel_column=0; frame_start=0; horiz_sync, vert_sync and all delay stages=1.
REQ-025 Reset mid-frame aborts immediately; after release the first tick occurs DIV clk later and counting resumes from (0,0).

Structure
REQ-026 Timing defaults, H_total/V_total and sync window bounds live in a shared package, vga_pkg, also used by the colour and decider stages.
REQ-027 The tick divider is a sub-module, pix_tick_gen (parameter DIV, output tick); counters and decode stay in vga_timing_gen.

Verification
REQ-028 Reset release with DIV=4: first tick at clk 4; h_cnt=1 after it; line period is 3200 clk; frame period is 1,680,000 clk.
REQ-029 Horizontal sync: horiz_sync low for 384 consecutive clk per line, falling 1+SYNC_DLY clk after h_cnt reaches 656.
REQ-030 Vertical sync: vert_sync low for exactly 2 lines (6400 clk) per frame, starting at v_cnt=490.
REQ-031 Active area: video_on is high for 640 ticks per line on lines 0..479 and low on lines 480..524; a bench count gives 307,200 active ticks per frame.
REQ-032 Frame wrap: exactly one frame_start pulse per 1,680,000 clk, coincident with pixel_row=0 and pixel_column=0.
REQ-033 Reset asserted at v_cnt=300, h_cnt=500: outputs are at reset values within the same clk; after release, sync timing restarts from (0,0) and no frame_start is produced.
